// File: rtl/fifobram_multichannel.sv
// fifobram_multichannel: NUM_CHANNELS independent FIFOs sharing one
// simple-dual-port BRAM partitioned by channel index. Each channel has
// its own pointers, occupancy count and status flags. Reads come back
// after READ_LATENCY cycles with a channel tag. Overflow and underflow
// flags stay set until reset.
module fifobram_multichannel #(
    parameter int WIDTH            = 512,
    parameter int LOG2_DEPTH       = 9,
    parameter int LOG2_CHANNELS    = 2,
    parameter int ALMOSTFULL_SLACK = 16,
    parameter int READ_LATENCY     = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       we,
    input  logic [LOG2_CHANNELS-1:0]                   wchannel,
    input  logic [WIDTH-1:0]                           wdata,
    input  logic                                       re,
    input  logic [LOG2_CHANNELS-1:0]                   rchannel,
    output logic [WIDTH-1:0]                           rdata,
    output logic                                       rvalid,
    output logic [LOG2_CHANNELS-1:0]                   rvalid_channel,
    input  logic                                       clear,
    input  logic [LOG2_CHANNELS-1:0]                   clear_channel,
    output logic [(2**LOG2_CHANNELS)*(LOG2_DEPTH+1)-1:0] count,
    output logic [(2**LOG2_CHANNELS)-1:0]              almostfull,
    output logic [(2**LOG2_CHANNELS)-1:0]              empty,
    output logic                                       overflow_err,
    output logic                                       underflow_err
);

    localparam int DEPTH        = 2**LOG2_DEPTH;
    localparam int NUM_CHANNELS = 2**LOG2_CHANNELS;
    localparam int CW           = LOG2_DEPTH + 1;
    localparam int AW           = LOG2_CHANNELS + LOG2_DEPTH;

    localparam logic [CW-1:0]           FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0]           AF_LEVEL   = CW'(DEPTH - ALMOSTFULL_SLACK);
    localparam logic [CW-1:0]           CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]           CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [LOG2_DEPTH-1:0]   PTR_ZERO   = {LOG2_DEPTH{1'b0}};
    localparam logic [LOG2_DEPTH-1:0]   PTR_ONE    = {{(LOG2_DEPTH-1){1'b0}}, 1'b1};
    localparam logic [NUM_CHANNELS-1:0] ONE_HOT0   = {{(NUM_CHANNELS-1){1'b0}}, 1'b1};

    // Shared storage, addressed as {channel, pointer}.
    logic [WIDTH-1:0] mem [0:NUM_CHANNELS*DEPTH-1];

    logic [LOG2_DEPTH-1:0] wptr_r      [NUM_CHANNELS];
    logic [LOG2_DEPTH-1:0] rptr_r      [NUM_CHANNELS];
    logic [CW-1:0]         count_r     [NUM_CHANNELS];
    logic [LOG2_DEPTH-1:0] wptr_nxt_s  [NUM_CHANNELS];
    logic [LOG2_DEPTH-1:0] rptr_nxt_s  [NUM_CHANNELS];
    logic [CW-1:0]         count_nxt_s [NUM_CHANNELS];

    logic                     wr_clear_hit_s;
    logic                     rd_clear_hit_s;
    logic                     rd_accept_s;
    logic                     wr_accept_s;
    logic                     overflow_set_s;
    logic                     underflow_set_s;
    logic [NUM_CHANNELS-1:0]  wr_hit_s;
    logic [NUM_CHANNELS-1:0]  rd_hit_s;
    logic [NUM_CHANNELS-1:0]  clr_hit_s;
    logic [AW-1:0]            waddr_s;
    logic [AW-1:0]            raddr_s;

    logic [WIDTH-1:0]         rd_data_r  [READ_LATENCY];
    logic [LOG2_CHANNELS-1:0] rd_chan_r  [READ_LATENCY];
    logic [READ_LATENCY-1:0]  rd_valid_r;
    logic                     overflow_r;
    logic                     underflow_r;

    // A clear on the same channel masks that cycle's request without error.
    assign wr_clear_hit_s = clear && (clear_channel == wchannel);
    assign rd_clear_hit_s = clear && (clear_channel == rchannel);

    // Reads only look at the registered count: no same-cycle write bypass.
    assign rd_accept_s = re && !rd_clear_hit_s && (count_r[rchannel] != CNT_ZERO);
    // A full channel still takes a write if a read of it frees a slot now.
    assign wr_accept_s = we && !wr_clear_hit_s &&
                         ((count_r[wchannel] != FULL_COUNT) ||
                          (rd_accept_s && (rchannel == wchannel)));

    assign overflow_set_s  = we && !wr_clear_hit_s && !wr_accept_s;
    assign underflow_set_s = re && !rd_clear_hit_s && !rd_accept_s;

    assign wr_hit_s  = wr_accept_s ? (ONE_HOT0 << wchannel)      : {NUM_CHANNELS{1'b0}};
    assign rd_hit_s  = rd_accept_s ? (ONE_HOT0 << rchannel)      : {NUM_CHANNELS{1'b0}};
    assign clr_hit_s = clear       ? (ONE_HOT0 << clear_channel) : {NUM_CHANNELS{1'b0}};

    assign waddr_s = {wchannel, wptr_r[wchannel]};
    assign raddr_s = {rchannel, rptr_r[rchannel]};

    // Per-channel pointer/count next state from accepted operations and clear.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wptr_nxt_s[c]  = wptr_r[c];
            rptr_nxt_s[c]  = rptr_r[c];
            count_nxt_s[c] = count_r[c];
            if (clr_hit_s[c]) begin
                wptr_nxt_s[c]  = PTR_ZERO;
                rptr_nxt_s[c]  = PTR_ZERO;
                count_nxt_s[c] = CNT_ZERO;
            end else begin
                if (wr_hit_s[c]) begin
                    wptr_nxt_s[c] = wptr_r[c] + PTR_ONE;
                end else begin
                    wptr_nxt_s[c] = wptr_r[c];
                end
                if (rd_hit_s[c]) begin
                    rptr_nxt_s[c] = rptr_r[c] + PTR_ONE;
                end else begin
                    rptr_nxt_s[c] = rptr_r[c];
                end
                case ({wr_hit_s[c], rd_hit_s[c]})
                    2'b10:   count_nxt_s[c] = count_r[c] + CNT_ONE;
                    2'b01:   count_nxt_s[c] = count_r[c] - CNT_ONE;
                    default: count_nxt_s[c] = count_r[c];
                endcase
            end
        end
    end

    // Pointer, count and sticky error state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wptr_r[c]  <= PTR_ZERO;
                rptr_r[c]  <= PTR_ZERO;
                count_r[c] <= CNT_ZERO;
            end
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wptr_r[c]  <= wptr_nxt_s[c];
                rptr_r[c]  <= rptr_nxt_s[c];
                count_r[c] <= count_nxt_s[c];
            end
            overflow_r  <= overflow_r  | overflow_set_s;
            underflow_r <= underflow_r | underflow_set_s;
        end
    end

    // BRAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem[waddr_s] <= wdata;
        end
    end

    // BRAM read port plus data delay line (read-before-write on a shared slot).
    always_ff @(posedge clk) begin
        if (rd_accept_s) begin
            rd_data_r[0] <= mem[raddr_s];
        end
        for (int k = 1; k < READ_LATENCY; k++) begin
            rd_data_r[k] <= rd_data_r[k-1];
        end
    end

    // Valid/channel tag delay line; reset squashes reads in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= {READ_LATENCY{1'b0}};
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_chan_r[k] <= {LOG2_CHANNELS{1'b0}};
            end
        end else begin
            rd_valid_r[0] <= rd_accept_s;
            rd_chan_r[0]  <= rchannel;
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_valid_r[k] <= rd_valid_r[k-1];
                rd_chan_r[k]  <= rd_chan_r[k-1];
            end
        end
    end

    assign rdata          = rd_data_r[READ_LATENCY-1];
    assign rvalid         = rd_valid_r[READ_LATENCY-1];
    assign rvalid_channel = rd_chan_r[READ_LATENCY-1];
    assign overflow_err   = overflow_r;
    assign underflow_err  = underflow_r;

    // Status flags are decoded straight from the registered counts.
    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_status
            assign count[g*CW +: CW] = count_r[g];
            assign empty[g]          = (count_r[g] == CNT_ZERO);
            assign almostfull[g]     = (count_r[g] >= AF_LEVEL);
        end
    endgenerate

endmodule

// File: tb/tb_fifobram_multichannel.sv
// Self-checking bench for fifobram_multichannel: directed scenarios plus
// a random phase, checked every cycle against a queue-based model.
module tb_fifobram_multichannel;

    localparam int W    = 64;
    localparam int LD   = 9;
    localparam int LC   = 2;
    localparam int SL   = 16;
    localparam int RL   = 2;
    localparam int DEP  = 2**LD;
    localparam int NCH  = 2**LC;
    localparam int CW   = LD + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              we;
    logic [LC-1:0]     wchannel;
    logic [W-1:0]      wdata;
    logic              re;
    logic [LC-1:0]     rchannel;
    logic [W-1:0]      rdata;
    logic              rvalid;
    logic [LC-1:0]     rvalid_channel;
    logic              clear;
    logic [LC-1:0]     clear_channel;
    logic [NCH*CW-1:0] count;
    logic [NCH-1:0]    almostfull;
    logic [NCH-1:0]    empty;
    logic              overflow_err;
    logic              underflow_err;

    fifobram_multichannel #(
        .WIDTH(W), .LOG2_DEPTH(LD), .LOG2_CHANNELS(LC),
        .ALMOSTFULL_SLACK(SL), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .we(we), .wchannel(wchannel), .wdata(wdata),
        .re(re), .rchannel(rchannel),
        .rdata(rdata), .rvalid(rvalid), .rvalid_channel(rvalid_channel),
        .clear(clear), .clear_channel(clear_channel),
        .count(count), .almostfull(almostfull), .empty(empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [LC-1:0] ch;
        logic [W-1:0] data;
    } pend_t;

    logic [W-1:0] mq [NCH][$];
    pend_t        pend [$];
    bit           m_ovf;
    bit           m_unf;
    int           cyc;
    int           n_total;
    int           n_bad;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] dut_count(input int c);
        return count[c*CW +: CW];
    endfunction

    task automatic idle_inputs();
        we = 1'b0; wchannel = '0; wdata = '0;
        re = 1'b0; rchannel = '0;
        clear = 1'b0; clear_channel = '0;
    endtask

    // Advance one clock: evaluate the model on the present inputs, then compare.
    task automatic tick();
        bit wclr, rclr, racc, wacc;
        logic [W-1:0] rd_word;
        wclr = clear && (clear_channel == wchannel);
        rclr = clear && (clear_channel == rchannel);
        racc = re && !rclr && (mq[rchannel].size() > 0);
        wacc = we && !wclr && ((mq[wchannel].size() < DEP) || (racc && rchannel == wchannel));
        @(posedge clk);
        #1;
        if (reset) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            pend.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (we && !wclr && !wacc) m_ovf = 1'b1;
            if (re && !rclr && !racc) m_unf = 1'b1;
            if (racc) begin
                rd_word = mq[rchannel].pop_front();
                pend.push_back('{due: cyc + RL, ch: rchannel, data: rd_word});
            end
            if (wacc) mq[wchannel].push_back(wdata);
            if (clear) mq[clear_channel].delete();
        end
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            check("rvalid", W'(rvalid), W'(1));
            check("rvalid_channel", W'(rvalid_channel), W'(pend[0].ch));
            check("rdata", rdata, pend[0].data);
            void'(pend.pop_front());
        end else begin
            check("rvalid_idle", W'(rvalid), W'(0));
        end
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("count%0d", c), W'(dut_count(c)), W'(mq[c].size()));
            check($sformatf("empty%0d", c), W'(empty[c]), W'(mq[c].size() == 0));
            check($sformatf("almostfull%0d", c), W'(almostfull[c]), W'(mq[c].size() >= DEP - SL));
        end
        check("overflow_err", W'(overflow_err), W'(m_ovf));
        check("underflow_err", W'(underflow_err), W'(m_unf));
    endtask

    task automatic do_write(input int ch, input logic [W-1:0] d);
        idle_inputs();
        we = 1'b1; wchannel = LC'(ch); wdata = d;
        tick();
    endtask

    task automatic do_read(input int ch);
        idle_inputs();
        re = 1'b1; rchannel = LC'(ch);
        tick();
    endtask

    task automatic do_idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        n_total = 0; n_bad = 0; cyc = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
        reset = 1'b1;
        idle_inputs();

        // Reset state.
        do_reset(3);
        check("reset_empty", W'(empty), W'(4'hF));
        check("reset_count", W'(count), W'(0));

        // Four words through ch1, back-to-back reads.
        for (int i = 0; i < 4; i++) do_write(1, W'(8'hA0 + i));
        check("ch1_count4", W'(dut_count(1)), W'(4));
        for (int i = 0; i < 4; i++) do_read(1);
        do_idle(RL + 1);
        check("ch1_empty_after", W'(empty[1]), W'(1));

        // Fill ch0 to DEPTH, then overflow, then simultaneous re+we at full.
        for (int i = 0; i < DEP; i++) begin
            do_write(0, {$urandom, $urandom});
            if (i == DEP - SL - 2) check("af_before", W'(almostfull[0]), W'(0));
            if (i == DEP - SL - 1) check("af_at_496", W'(almostfull[0]), W'(1));
        end
        check("ch0_full", W'(dut_count(0)), W'(DEP));
        do_write(0, {$urandom, $urandom});
        check("ovf_set", W'(overflow_err), W'(1));
        idle_inputs();
        we = 1'b1; wchannel = 2'd0; wdata = {$urandom, $urandom};
        re = 1'b1; rchannel = 2'd0;
        tick();
        check("ch0_full_rw", W'(dut_count(0)), W'(DEP));
        do_idle(RL);

        // Read of empty ch2 together with a write: no bypass.
        idle_inputs();
        we = 1'b1; wchannel = 2'd2; wdata = 64'h0000_C0DE_2222_0001;
        re = 1'b1; rchannel = 2'd2;
        tick();
        check("unf_set", W'(underflow_err), W'(1));
        check("ch2_count1", W'(dut_count(2)), W'(1));
        do_read(2);
        do_idle(RL);

        // Stream into ch3 while ch0 drains; then keep ch3 flowing past wrap.
        for (int i = 0; i < 1000; i++) begin
            idle_inputs();
            we = 1'b1; wchannel = 2'd3; wdata = {$urandom, $urandom};
            re = 1'b1;
            rchannel = (mq[0].size() > 0) ? 2'd0 : 2'd3;
            tick();
        end
        do_idle(RL);

        // Clear with reads in flight on ch1.
        for (int i = 0; i < 3; i++) do_write(1, {$urandom, $urandom});
        do_read(1);
        do_read(1);
        idle_inputs();
        clear = 1'b1; clear_channel = 2'd1;
        re = 1'b1; rchannel = 2'd1;
        tick();
        check("ch1_cleared", W'(dut_count(1)), W'(0));
        do_idle(RL + 1);

        // Reset with two reads in flight.
        do_write(2, {$urandom, $urandom});
        do_write(2, {$urandom, $urandom});
        do_read(2);
        do_read(2);
        do_reset(1);
        do_idle(RL + 2);
        check("post_reset_count", W'(count), W'(0));
        check("post_reset_ovf", W'(overflow_err), W'(0));
        check("post_reset_unf", W'(underflow_err), W'(0));

        // Random mixed traffic.
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            we       = ($urandom_range(0, 99) < 55);
            wchannel = LC'($urandom_range(0, NCH - 1));
            wdata    = {$urandom, $urandom};
            re       = ($urandom_range(0, 99) < 50);
            rchannel = LC'($urandom_range(0, NCH - 1));
            clear    = ($urandom_range(0, 99) < 2);
            clear_channel = LC'($urandom_range(0, NCH - 1));
            tick();
        end
        do_idle(RL + 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifobram_multichannel.md
Name: fifobram_multichannel

Overview:
- Parametrised successor of the single-queue fifo_source block: NUM_CHANNELS independent FIFOs share one simple-dual-port BRAM, which is partitioned by channel index.
- Sits between the common read/write engines and the compute pipelines, so one memory-read engine can prefetch into several per-channel queues.
- Adds features the single queue lacks:
  - per-channel count/almostfull/empty,
  - configurable read latency with a channel-tagged rvalid,
  - per-channel clear,
  - sticky overflow/underflow flags.

Parameters:
- WIDTH, 512, data width in bits.
- LOG2_DEPTH, 9, log2 of entries per channel; DEPTH = 2**LOG2_DEPTH.
- LOG2_CHANNELS, 2, log2 of channel count; NUM_CHANNELS = 2**LOG2_CHANNELS.
- ALMOSTFULL_SLACK, 16, almostfull asserts when count >= DEPTH - ALMOSTFULL_SLACK; legal range 1..DEPTH-1.
- READ_LATENCY, 2, cycles from accepted re to rvalid; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write request.
- wchannel  in  LOG2_CHANNELS  target channel of write.
- wdata  in  WIDTH  write data.
- re  in  1  read request.
- rchannel  in  LOG2_CHANNELS  source channel of read.
- rdata  out  WIDTH  read data; valid only while rvalid=1.
- rvalid  out  1  rdata valid strobe.
- rvalid_channel  out  LOG2_CHANNELS  channel of the current rdata.
- clear  in  1  flush one channel.
- clear_channel  in  LOG2_CHANNELS  channel to flush.
- count  out  NUM_CHANNELS*(LOG2_DEPTH+1)  per-channel occupancy; channel c at bits [c*(LOG2_DEPTH+1) +: LOG2_DEPTH+1].
- almostfull  out  NUM_CHANNELS  per-channel almostfull.
- empty  out  NUM_CHANNELS  per-channel empty.
- overflow_err  out  1  sticky: a write was dropped.
- underflow_err  out  1  sticky: a read was ignored.

Behaviour:
- The clock is clk. Reset is synchronous and active-high on reset; there is a single clock domain.
- Reset state:
  - All wptr/rptr/count are 0; empty is all-ones; almostfull is 0.
  - rvalid, rvalid_channel and the latency pipeline are 0; pending reads are squashed.
  - overflow_err and underflow_err are 0.
  - rdata is don't-care. BRAM contents are not reset.
- Storage: BRAM address = {channel, ptr}, with LOG2_CHANNELS+LOG2_DEPTH bits in total.
- Pointers are LOG2_DEPTH bits and wrap naturally from DEPTH-1 to 0.
- count is LOG2_DEPTH+1 bits, so a full channel reads DEPTH.
- Write accept rule: we=1, no clear on wchannel, and either count[wchannel]<DEPTH or a read of the same channel is accepted in the same cycle.
  - On accept: write the BRAM, wptr+1.
  - On refusal: drop the data, set overflow_err, leave state unchanged.
- Read accept rule: re=1, no clear on rchannel, and count[rchannel]>0. Only the registered count is used; there is no write-to-read bypass.
  - On accept: issue the BRAM read, rptr+1.
  - On refusal: set underflow_err; no rvalid is produced.
- An accepted read at cycle t gives rvalid=1 with rdata/rvalid_channel at cycle t+READ_LATENCY. Back-to-back reads give one result per cycle, in order.
- Count update, registered, visible at t+1 (per channel, accounting for accepted operations only):
  - +1 for a write alone,
  - -1 for a read alone,
  - unchanged when both hit the same channel.
- Data written at cycle t is readable by a re at t+1 or later.
- Status outputs are combinational from the registered counts:
  - empty[c] = (count==0).
  - almostfull[c] = (count >= DEPTH-ALMOSTFULL_SLACK).
- clear: at the clock edge, wptr, rptr and count of clear_channel go to 0.
  - Same-cycle we/re on that channel are ignored and set no error flags.
  - Reads already in flight still deliver their rvalid.
  - Other channels are unaffected.
- Writes and reads on different channels proceed independently in the same cycle.
- Error flags are sticky until reset.

Test Plan:
- Reset, then write 0xA0..0xA3 on ch1, then re ch1 ×4 back-to-back from cycle 10 → rvalid at cycles 12..15 with data 0xA0..0xA3 and rvalid_channel=1; count[1]: 4→0; empty[1]=1 afterwards.
- Write DEPTH=512 entries to ch0 → almostfull[0] rises when count reaches 496; count=512; a 513th write is dropped and overflow_err=1; a simultaneous re+we on ch0 at full is accepted and count stays 512.
- re on empty ch2 together with we ch2 in the same cycle → no rvalid, underflow_err=1, count[2]=1 next cycle; re ch2 one cycle later returns the written word.
- Interleave we ch3 and re ch0 every cycle for 1000 cycles with ch0 prefilled → no cross-channel corruption; the ch3 pointer wraps past 511 and data order is preserved.
- Issue 2 reads on ch1, assert clear ch1 with re ch1 in the next cycle → both earlier reads still deliver; the clear-cycle read is ignored with no error; count[1]=0.
- Assert reset while 2 reads are in flight → no rvalid afterwards; all counts 0; error flags 0.
